// File: rtl/msrv32_lsu_ctrl.sv
// Load/store sequencing controller for msrv32. It runs one req/ack data-memory
// transaction per accepted request, stalls the pipeline while it is outstanding and returns extended load data.
module msrv32_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        ld_req_in,
    input  logic        st_req_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic        misaligned_in,
    input  logic        trap_taken_in,
    output logic        dmem_req_out,
    output logic        dmem_wr_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wmask_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        stall_out,
    output logic        bus_error_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic        abort_reg;
    logic [1:0]  lane_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;

    logic        accept;
    logic [7:0]  cnt_next;
    logic        timeout;
    logic [31:0] wdata_next;
    logic [3:0]  wmask_next;
    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Reset is folded in so stall never rises while the core is held in reset.
    assign accept    = (state_reg == IDLE) && (ld_req_in || st_req_in) && !misaligned_in
                       && !trap_taken_in && !ms_riscv32_mp_rst_in;
    assign stall_out = accept || (state_reg == ACCESS);

    // The threshold compares the count including the current cycle, so the
    // error is raised after exactly TIMEOUT_CYCLES unacknowledged ACCESS cycles.
    assign cnt_next = cnt_reg + 8'd1;
    assign timeout  = (cnt_next == TIMEOUT_LIMIT);

    always_comb begin
        wdata_next = store_data_in;
        wmask_next = 4'b1111;
        case (load_size_in)
            2'b00: begin
                wdata_next = {4{store_data_in[7:0]}};
                wmask_next = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
                wdata_next = {2{store_data_in[15:0]}};
                wmask_next = 4'b0011 << addr_in[1:0];
            end
            default: begin
                wdata_next = store_data_in;
                wmask_next = 4'b1111;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = dmem_rdata_in[8*gi +: 8];
    end

    assign byte_sel = rd_byte[lane_reg];
    assign half_sel = lane_reg[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];

    always_comb begin
        load_ext = dmem_rdata_in;
        case (size_reg)
            2'b00:   load_ext = {{24{!unsigned_reg && byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{!unsigned_reg && half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata_in;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            abort_reg      <= 1'b0;
            lane_reg       <= 2'b00;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
            dmem_req_out   <= 1'b0;
            dmem_wr_out    <= 1'b0;
            dmem_addr_out  <= 32'd0;
            dmem_wdata_out <= 32'd0;
            dmem_wmask_out <= 4'b0000;
            load_data_out  <= 32'd0;
            load_valid_out <= 1'b0;
            bus_error_out  <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            bus_error_out  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    abort_reg <= 1'b0;
                    cnt_reg   <= 8'd0;
                    if (accept) begin
                        state_reg      <= ACCESS;
                        dmem_req_out   <= 1'b1;
                        dmem_wr_out    <= st_req_in;
                        dmem_addr_out  <= {addr_in[31:2], 2'b00};
                        dmem_wdata_out <= wdata_next;
                        dmem_wmask_out <= st_req_in ? wmask_next : 4'b0000;
                        lane_reg       <= addr_in[1:0];
                        size_reg       <= load_size_in;
                        unsigned_reg   <= load_unsigned_in;
                    end
                end
                ACCESS: begin
                    abort_reg <= abort_reg || trap_taken_in;
                    if (dmem_ack_in) begin
                        dmem_req_out <= 1'b0;
                        cnt_reg      <= 8'd0;
                        if (dmem_wr_out) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg      <= DONE;
                            load_data_out  <= load_ext;
                            load_valid_out <= !(abort_reg || trap_taken_in);
                        end
                    end else if (timeout) begin
                        dmem_req_out  <= 1'b0;
                        cnt_reg       <= 8'd0;
                        bus_error_out <= 1'b1;
                        state_reg     <= ERR;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                DONE: state_reg <= IDLE;
                ERR:  state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/msrv32_lsu_ctrl.md
Name: msrv32_lsu_ctrl

Overview:
Load/store sequencing controller for the msrv32 core. Takes the decoder's load/store request, size, signedness and misalignment flags, then runs one data-memory transaction over a req/ack bus. Stalls the pipeline while the transaction is outstanding and returns lane-aligned, extended load data. Sits between the decoder/execute stage and the data-memory port; misaligned accesses are left to the trap logic.

Parameters:
TIMEOUT_CYCLES, 15, ACCESS-state cycles without ack before a bus error is declared (1..255)

Ports:
ms_riscv32_mp_clk_in  input  1  core clock
ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
ld_req_in  input  1  decoded load in execute stage
st_req_in  input  1  decoded store in execute stage (mem_wr_req from decoder)
addr_in  input  32  effective address (iadder result)
store_data_in  input  32  rs2 value
load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
load_unsigned_in  input  1  1 = zero-extend load
misaligned_in  input  1  decoder misaligned_load OR misaligned_store
trap_taken_in  input  1  trap accepted this cycle
dmem_req_out  output  1  bus request
dmem_wr_out  output  1  1 = write
dmem_addr_out  output  32  word-aligned address
dmem_wdata_out  output  32  lane-replicated store data
dmem_wmask_out  output  4  byte write enables (0 for loads)
dmem_ack_in  input  1  bus completion; rdata valid same cycle for loads
dmem_rdata_in  input  32  read word
load_data_out  output  32  extended load result
load_valid_out  output  1  one-cycle load-result strobe
stall_out  output  1  hold pipeline
bus_error_out  output  1  one-cycle timeout pulse

Behaviour:
- Clock, reset: one clock, ms_riscv32_mp_clk_in; reset ms_riscv32_mp_rst_in is synchronous and active-high.
- Reset: state IDLE, timeout counter 0, abort flag 0. All outputs 0, including load_data_out.
- States: IDLE, ACCESS, DONE, ERR.
- accept = IDLE & (ld_req_in | st_req_in) & !misaligned_in & !trap_taken_in.
  - If ld_req_in and st_req_in are both high, the store wins.
- Misaligned or trapped request in IDLE: no bus activity, no stall, no state change.
- On accept, register the following and go to ACCESS next cycle:
  - address, op, size, unsigned flag
  - dmem_wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d
  - dmem_wmask: byte 0001<<a[1:0], half 0011<<a[1:0], word 1111; loads 0000
- stall_out = accept | (state==ACCESS). It is combinational, so it is already high in the accept cycle.
- ACCESS:
  - dmem_req_out=1. Address, wr, wdata and mask are held stable until ack.
  - dmem_addr_out = {addr[31:2],2'b00}.
  - Counter increments each cycle without ack.
- ack in ACCESS:
  - Store: go to IDLE.
  - Load: go to DONE and register the extracted lane. Byte lane = a[1:0]; half lane = a[1]; sign- or zero-extend per the unsigned flag.
  - Counter is cleared.
- DONE: load_valid_out=1 for exactly one cycle unless abort is set; stall_out=0; then IDLE.
  - A new accept is not possible in DONE; it is taken the following IDLE cycle.
- Timeout: counter == TIMEOUT_CYCLES with no ack in that cycle → ERR.
  - In ERR: dmem_req_out=0, bus_error_out=1 for one cycle, stall_out=0, then IDLE, counter cleared.
  - An ack arriving in the same cycle as the timeout threshold wins: normal completion.
- trap_taken_in during ACCESS: the request is not withdrawn. Set abort, and complete on ack or timeout.
  - Abort suppresses load_valid_out only; load_data_out still updates.
  - Abort clears on return to IDLE.
- dmem_ack_in outside ACCESS is ignored.
- Reset mid-transaction: immediate return to IDLE; dmem_req_out drops the next edge.
- Bus outputs other than dmem_req_out hold their last values when idle.

Test Plan:
- Word store: st_req, addr 0x100, data 0xDEADBEEF, size 10, ack after 2 cycles → req/wr=1, addr 0x100, mask 1111, stall high accept+2 ACCESS cycles, IDLE after ack.
- Signed byte load: addr 0x203, rdata 0x80FF_FF7F... lane3=0x80, ack 1st cycle → load_data 0xFFFFFF80, load_valid one pulse in DONE.
- Unsigned half load: addr 0x202, rdata 0xBEEF1234 → load_data 0x0000BEEF. Store half 0xABCD @0x06 → wdata 0xABCDABCD, mask 1100.
- Misaligned: ld_req, addr 0x101, size 10, misaligned_in=1 → no dmem_req, stall 0, state IDLE.
- Timeout: load, never ack, TIMEOUT_CYCLES=15 → 15 ACCESS cycles, then bus_error pulse, req low, stall low. Repeat with ack in the threshold cycle → normal completion, no error.
- Trap during ACCESS: trap_taken_in pulse, ack 3 cycles later → transaction completes, load_valid stays 0. Reset asserted mid-ACCESS → all outputs 0 next cycle.
